// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture
// Function : OV7670-style RGB565 camera capture into a linear 8-bit frame
//            buffer write port. Define CAM_CAPTURE_GRAY_EN for 8-bit luma.
// Revision : 1.0
// ============================================================================
module cam_capture #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int WORD_DEPTH = H_PIXELS * V_LINES,
  parameter int ADDR_W     = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cam_pclk_i,
  input  logic              cam_vsync_i,
  input  logic              cam_href_i,
  input  logic [7:0]        cam_d_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [7:0]        dat_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic              short_frame_o
);

  // Never write past either the buffer or the nominal frame geometry.
  localparam int CNT_MAX = (WORD_DEPTH < H_PIXELS * V_LINES) ? WORD_DEPTH : H_PIXELS * V_LINES;
  localparam logic [ADDR_W-1:0] CNT_LIMIT = ADDR_W'(CNT_MAX);

`ifdef CAM_CAPTURE_GRAY_EN
  localparam int HI_W  = 8;
  localparam int PIX_W = 16;
`else
  localparam int HI_W  = 6;
  localparam int PIX_W = 8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [2:0] pclk_sync_q;
  logic [2:0] vsync_sync_q;
  logic [1:0] href_sync_q;
  logic [7:0] d_sync1_q;
  logic [7:0] d_sync2_q;
  logic       pclk_rise_q;
  logic       vsync_rise_q;
  logic       vsync_fall_q;
  logic       href_q;
  logic [7:0] byte_q;

  // Bit [2] of each sync chain is the previous synced sample for edge detect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      d_sync1_q    <= '0;
      d_sync2_q    <= '0;
      pclk_rise_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      vsync_fall_q <= 1'b0;
      href_q       <= 1'b0;
      byte_q       <= '0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[1:0], cam_pclk_i};
      vsync_sync_q <= {vsync_sync_q[1:0], cam_vsync_i};
      href_sync_q  <= {href_sync_q[0], cam_href_i};
      d_sync1_q    <= cam_d_i;
      d_sync2_q    <= d_sync1_q;
      pclk_rise_q  <= pclk_sync_q[1] & ~pclk_sync_q[2];
      vsync_rise_q <= vsync_sync_q[1] & ~vsync_sync_q[2];
      vsync_fall_q <= ~vsync_sync_q[1] & vsync_sync_q[2];
      href_q       <= href_sync_q[1];
      byte_q       <= d_sync2_q;
    end
  end

  state_t            state_d, state_q;
  logic              phase_d, phase_q;
  logic [HI_W-1:0]   hi_d, hi_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              wr_d, wr_q;
  logic [ADDR_W-1:0] wr_adr_d, wr_adr_q;
  logic [PIX_W-1:0]  wr_pix_d, wr_pix_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              ovf_d, ovf_q;
  logic              short_d, short_q;
  logic [HI_W-1:0]   w_hi_next;
  logic [PIX_W-1:0]  w_pix_next;

`ifdef CAM_CAPTURE_GRAY_EN
  assign w_hi_next  = byte_q;
  assign w_pix_next = {hi_q, byte_q};
`else
  // Only R[4:2] and G[5:3] of the high byte survive RGB332 packing.
  assign w_hi_next  = {byte_q[7:5], byte_q[2:0]};
  assign w_pix_next = {hi_q, byte_q[4:3]};
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    wr_adr_d = wr_adr_q;
    wr_pix_d = wr_pix_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    short_d  = short_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ARM;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          short_d = 1'b0;
        end
      end
      ST_ARM: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (vsync_fall_q) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vsync_rise_q) begin
          state_d = ST_DONE;
        end else if (!href_q) begin
          phase_d = 1'b0;
        end else if (pclk_rise_q) begin
          if (!phase_q) begin
            hi_d    = w_hi_next;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (cnt_q == CNT_LIMIT) begin
              ovf_d = 1'b1;
            end else begin
              wr_d     = 1'b1;
              wr_adr_d = cnt_q;
              wr_pix_d = w_pix_next;
              cnt_d    = cnt_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (cnt_q < CNT_LIMIT) short_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      wr_adr_q <= '0;
      wr_pix_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      wr_adr_q <= wr_adr_d;
      wr_pix_q <= wr_pix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      short_q  <= short_d;
    end
  end

  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign overflow_o    = ovf_q;
  assign short_frame_o = short_q;

`ifdef CAM_CAPTURE_GRAY_EN
  logic [7:0]        r8, g8, b8;
  logic [15:0]       y_sum;
  logic              we_g_q;
  logic [ADDR_W-1:0] adr_g_d, adr_g_q;
  logic [7:0]        dat_g_d, dat_g_q;

  // Bit-replicated 8-bit channels; weighted sum fits 16 bits (max 65280).
  always_comb begin
    r8      = {wr_pix_q[15:11], wr_pix_q[15:13]};
    g8      = {wr_pix_q[10:5], wr_pix_q[10:9]};
    b8      = {wr_pix_q[4:0], wr_pix_q[4:2]};
    y_sum   = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    adr_g_d = wr_q ? wr_adr_q : adr_g_q;
    dat_g_d = wr_q ? 8'(y_sum >> 8) : dat_g_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_g_q  <= 1'b0;
      adr_g_q <= '0;
      dat_g_q <= '0;
    end else begin
      we_g_q  <= wr_q;
      adr_g_q <= adr_g_d;
      dat_g_q <= dat_g_d;
    end
  end

  assign we_o  = we_g_q;
  assign adr_o = adr_g_q;
  assign dat_o = dat_g_q;
`else
  assign we_o  = wr_q;
  assign adr_o = wr_adr_q;
  assign dat_o = wr_pix_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture
// Function : Randomized self-checking bench for cam_capture on a reduced frame.
// Revision : 1.0
// ============================================================================
module tb_cam_capture;

  localparam int H      = 16;
  localparam int V      = 8;
  localparam int DEPTH  = H * V;
  localparam int ADDR_W = 24;
`ifdef CAM_CAPTURE_GRAY_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cam_pclk = 1'b0;
  logic              cam_vsync = 1'b0;
  logic              cam_href = 1'b0;
  logic [7:0]        cam_d = 8'd0;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [7:0]        dat_o;
  logic              busy_o;
  logic              frame_done_o;
  logic              overflow_o;
  logic              short_frame_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int          done_cnt = 0;
  int          exp_cnt  = 0;
  bit          exp_ovf  = 1'b0;

  cam_capture #(
    .H_PIXELS  (H),
    .V_LINES   (V),
    .WORD_DEPTH(DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .cam_pclk_i   (cam_pclk),
    .cam_vsync_i  (cam_vsync),
    .cam_href_i   (cam_href),
    .cam_d_i      (cam_d),
    .we_o         (we_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o),
    .short_frame_o(short_frame_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (we_o === 1'b1) obs_q.push_back({adr_o, dat_o});
    if (frame_done_o === 1'b1) done_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: split RGB565 into channels, then pack or compute luma.
  function automatic logic [7:0] model_dat(input logic [7:0] hi, input logic [7:0] lo);
    int r, g, b, r8, g8, b8, y;
    r = int'(hi[7:3]);
    g = int'({hi[2:0], lo[7:5]});
    b = int'(lo[4:0]);
`ifdef CAM_CAPTURE_GRAY_EN
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
`else
    r8 = 0; g8 = 0; b8 = 0;
    y  = (r / 4) * 32 + (g / 8) * 4 + (b / 8);
`endif
    return 8'(y);
  endfunction

  task automatic model_pixel(input logic [7:0] hi, input logic [7:0] lo);
    if (exp_cnt < DEPTH) exp_q.push_back({24'(exp_cnt), model_dat(hi, lo)});
    else exp_ovf = 1'b1;
    exp_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cam_d    = b;
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pixels(input int n, input bit model_on);
    logic [7:0] hi, lo;
    int col = 0;
    @(negedge clk);
    cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      send_byte(hi);
      send_byte(lo);
      if (model_on) model_pixel(hi, lo);
      col++;
      if (col == H && i != n - 1) begin
        @(negedge clk);
        cam_href = 1'b0;
        idle(3);
        cam_href = 1'b1;
        col = 0;
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    idle(3);
  endtask

  task automatic vsync_set(input logic v);
    @(negedge clk);
    cam_vsync = v;
    idle(6);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_model();
    obs_q.delete();
    exp_q.delete();
    exp_cnt  = 0;
    exp_ovf  = 1'b0;
    done_cnt = 0;
  endtask

  task automatic frame_begin();
    clear_model();
    pulse_start();
    vsync_set(1'b1);
    vsync_set(1'b0);
  endtask

  task automatic frame_end();
    vsync_set(1'b1);
    idle(6);
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      cam_pclk  = 1'($urandom);
      cam_vsync = 1'($urandom);
      cam_href  = 1'($urandom);
      cam_d     = 8'($urandom);
    end
    outs = {1'b0, we_o, busy_o, frame_done_o, overflow_o, short_frame_o, 2'b00, dat_o, adr_o[15:0]};
    n_checks++;
    if (outs !== 32'd0 || adr_o !== '0) $display("FAIL reset_outputs got %h adr=%0d required 0", outs, adr_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (40) begin
      @(negedge clk);
      cam_pclk  = 1'($urandom);
      cam_vsync = 1'($urandom);
      cam_href  = 1'($urandom);
      cam_d     = 8'($urandom);
    end
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_d = 8'd0;
    idle(8);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL reset_no_write got %0d writes required 0", obs_q.size());
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || done_cnt !== 0) $display("FAIL reset_idle got busy=%b done=%0d required 0/0", busy_o, done_cnt);
    else n_pass++;
  endtask

  task automatic test_nominal();
    frame_begin();
    send_pixels(DEPTH, 1'b1);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL nominal_busy got %b required 1", busy_o);
    else n_pass++;
    frame_end();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL nominal_count got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL nominal_write[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 1 || busy_o !== 1'b0) $display("FAIL nominal_done got done=%0d busy=%b required 1/0", done_cnt, busy_o);
    else n_pass++;
    n_checks++;
    if (overflow_o !== exp_ovf || short_frame_o !== (exp_cnt < DEPTH))
      $display("FAIL nominal_flags got ovf=%b short=%b required %b/%b", overflow_o, short_frame_o, exp_ovf, exp_cnt < DEPTH);
    else n_pass++;
  endtask

  task automatic test_latency();
    int n = 0;
    frame_begin();
    @(negedge clk);
    cam_href = 1'b1;
    send_byte(8'hA5);
    @(negedge clk);
    cam_d    = 8'h3C;
    cam_pclk = 1'b1;
    model_pixel(8'hA5, 8'h3C);
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (we_o === 1'b1) break;
    end
    n_checks++;
    if (n !== LAT) $display("FAIL latency got %0d cycles required %0d", n, LAT);
    else n_pass++;
    n_checks++;
    if (dat_o !== model_dat(8'hA5, 8'h3C) || adr_o !== '0)
      $display("FAIL pack got dat=%h adr=%0d required dat=%h adr=0", dat_o, adr_o, model_dat(8'hA5, 8'h3C));
    else n_pass++;
    @(negedge clk);
    cam_pclk = 1'b0;
    idle(4);
    cam_href = 1'b0;
    idle(3);
    frame_end();
    n_checks++;
    if (obs_q.size() !== 1 || done_cnt !== 1 || short_frame_o !== 1'b1)
      $display("FAIL latency_frame got writes=%0d done=%0d short=%b required 1/1/1", obs_q.size(), done_cnt, short_frame_o);
    else n_pass++;
  endtask

  task automatic test_short_odd();
    frame_begin();
    send_pixels(10, 1'b1);
    @(negedge clk);
    cam_href = 1'b1;
    send_byte(8'($urandom));
    @(negedge clk);
    cam_href = 1'b0;
    idle(3);
    send_pixels(2, 1'b1);
    frame_end();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL short_count got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL short_write[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (short_frame_o !== 1'b1 || overflow_o !== 1'b0 || done_cnt !== 1)
      $display("FAIL short_flags got short=%b ovf=%b done=%0d required 1/0/1", short_frame_o, overflow_o, done_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    frame_begin();
    send_pixels(DEPTH + 2, 1'b1);
    frame_end();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL ovf_count got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_write[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (adr_o !== ADDR_W'(DEPTH - 1)) $display("FAIL ovf_last_adr got %0d required %0d", adr_o, DEPTH - 1);
    else n_pass++;
    n_checks++;
    if (overflow_o !== exp_ovf || short_frame_o !== 1'b0 || done_cnt !== 1)
      $display("FAIL ovf_flags got ovf=%b short=%b done=%0d required %b/0/1", overflow_o, short_frame_o, done_cnt, exp_ovf);
    else n_pass++;
  endtask

  task automatic test_arm_abort();
    vsync_set(1'b0);
    clear_model();
    pulse_start();
    send_pixels(4, 1'b0);
    vsync_set(1'b1);
    n_checks++;
    if (obs_q.size() !== 0 || busy_o !== 1'b1 || done_cnt !== 0)
      $display("FAIL arm_ignore got writes=%0d busy=%b done=%0d required 0/1/0", obs_q.size(), busy_o, done_cnt);
    else n_pass++;
    vsync_set(1'b0);
    send_pixels(3, 1'b1);
    pulse_start();
    send_pixels(3, 1'b1);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL busy_start_count got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL busy_start_write[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    @(negedge clk);
    cam_href = 1'b1;
    send_byte(8'h12);
    @(negedge clk);
    cam_d    = 8'h34;
    cam_pclk = 1'b1;
    idle(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (we_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL abort_we got we=%b busy=%b required 0/0", we_o, busy_o);
    else n_pass++;
    idle(5);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    rst_n    = 1'b1;
    idle(3);
    vsync_set(1'b1);
    vsync_set(1'b0);
    send_pixels(3, 1'b0);
    frame_end();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || done_cnt !== 0 || busy_o !== 1'b0)
      $display("FAIL abort_after got writes=%0d done=%0d busy=%b required %0d/0/0", obs_q.size(), done_cnt, busy_o, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_short_odd();
    test_overflow();
    test_arm_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
